// File: rtl/pad_alsaqr_cfg_seq.sv
// pad_alsaqr_cfg_seq: glitch-safe per-pad OEN/PUEN/DRV/SLW/SMT configuration sequencer
module pad_alsaqr_cfg_seq #(
    parameter int NUM_PADS = 8,
    parameter int SETTLE_CYCLES = 4,
    localparam int IDXW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [IDXW-1:0]       cfg_idx_i,
    input  logic [5:0]            cfg_data_i,
    output logic                  cfg_done_o,
    output logic                  cfg_err_o,
    output logic [NUM_PADS-1:0]   pad_oen_o,
    output logic [NUM_PADS-1:0]   pad_puen_o,
    output logic [2*NUM_PADS-1:0] pad_drv_o,
    output logic [NUM_PADS-1:0]   pad_slw_o,
    output logic [NUM_PADS-1:0]   pad_smt_o
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, TRI, APPLY} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [IDXW-1:0] idx;
    logic [5:0] data;
    logic in_range;
    assign cfg_ready_o = (state == IDLE) && !rst_i;
    assign in_range = 32'(cfg_idx_i) < NUM_PADS;
    // Electrical fields only move while the pad is tristated; OEN is restored last.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            data       <= '0;
            cfg_done_o <= 1'b0;
            cfg_err_o  <= 1'b0;
            pad_oen_o  <= '1;
            pad_puen_o <= '0;
            pad_drv_o  <= '0;
            pad_slw_o  <= '0;
            pad_smt_o  <= '0;
        end else begin
            cfg_done_o <= 1'b0;
            cfg_err_o  <= 1'b0;
            case (state)
                IDLE: if (cfg_valid_i) begin
                    idx  <= cfg_idx_i;
                    data <= cfg_data_i;
                    cnt  <= RELOAD;
                    if (!in_range) cfg_err_o <= 1'b1;
                    else if (!pad_oen_o[cfg_idx_i]) begin
                        pad_oen_o[cfg_idx_i] <= 1'b1;
                        state                <= TRI;
                    end else begin
                        pad_puen_o[cfg_idx_i]       <= cfg_data_i[4];
                        pad_drv_o[2*cfg_idx_i +: 2] <= cfg_data_i[3:2];
                        pad_slw_o[cfg_idx_i]        <= cfg_data_i[1];
                        pad_smt_o[cfg_idx_i]        <= cfg_data_i[0];
                        state                       <= APPLY;
                    end
                end
                TRI: if (cnt == '0) begin
                    pad_puen_o[idx]       <= data[4];
                    pad_drv_o[2*idx +: 2] <= data[3:2];
                    pad_slw_o[idx]        <= data[1];
                    pad_smt_o[idx]        <= data[0];
                    cnt                   <= RELOAD;
                    state                 <= APPLY;
                end else cnt <= cnt - CW'(1);
                APPLY: if (cnt == '0) begin
                    pad_oen_o[idx] <= data[5];
                    cfg_done_o     <= 1'b1;
                    state          <= IDLE;
                end else cnt <= cnt - CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pad_alsaqr_cfg_seq.sv
// tb_pad_alsaqr_cfg_seq: directed bench with a response scoreboard for the pad config sequencer
module tb_pad_alsaqr_cfg_seq;
    localparam int NP = 6;
    localparam int S = 4;
    localparam int IDXW = 3;
    typedef struct {
        logic err;
        int lat;
        logic [NP-1:0] oen, puen, slw, smt;
        logic [2*NP-1:0] drv;
    } exp_t;
    logic clk, rst_i, cfg_valid_i, cfg_ready_o, cfg_done_o, cfg_err_o;
    logic [IDXW-1:0] cfg_idx_i;
    logic [5:0] cfg_data_i;
    logic [NP-1:0] pad_oen_o, pad_puen_o, pad_slw_o, pad_smt_o;
    logic [2*NP-1:0] pad_drv_o;
    logic [NP-1:0] m_oen, m_puen, m_slw, m_smt;
    logic [2*NP-1:0] m_drv;
    exp_t q[$];
    int acc_q[$];
    int errors = 0, checks = 0, cyc = 0, n_acc = 0, last_acc = 0, done_cyc = 0, base;
    pad_alsaqr_cfg_seq #(.NUM_PADS(NP), .SETTLE_CYCLES(S)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_idx_i(cfg_idx_i), .cfg_data_i(cfg_data_i), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
        .pad_oen_o(pad_oen_o), .pad_puen_o(pad_puen_o), .pad_drv_o(pad_drv_o),
        .pad_slw_o(pad_slw_o), .pad_smt_o(pad_smt_o)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask
    task automatic model_reset();
        m_oen = '1; m_puen = '0; m_drv = '0; m_slw = '0; m_smt = '0;
    endtask
    task automatic check_all(input string tag);
        chk({tag, "_oen"}, 32'(pad_oen_o), 32'(m_oen));
        chk({tag, "_puen"}, 32'(pad_puen_o), 32'(m_puen));
        chk({tag, "_drv"}, 32'(pad_drv_o), 32'(m_drv));
        chk({tag, "_slw"}, 32'(pad_slw_o), 32'(m_slw));
        chk({tag, "_smt"}, 32'(pad_smt_o), 32'(m_smt));
    endtask
    task automatic issue(input int idx, input logic [5:0] d);
        exp_t e;
        cfg_valid_i = 1'b1;
        cfg_idx_i = IDXW'(idx);
        cfg_data_i = d;
        e.err = (idx >= NP);
        e.lat = 0;
        if (!e.err) begin
            e.lat = m_oen[idx] ? S : 2 * S;
            m_puen[idx] = d[4];
            m_drv[2*idx +: 2] = d[3:2];
            m_slw[idx] = d[1];
            m_smt[idx] = d[0];
            m_oen[idx] = d[5];
        end
        e.oen = m_oen; e.puen = m_puen; e.drv = m_drv; e.slw = m_slw; e.smt = m_smt;
        q.push_back(e);
    endtask
    task automatic tick();
        logic a, r;
        logic [NP-1:0] po, pp, ps, pm;
        logic [2*NP-1:0] pd, dmask;
        exp_t e;
        int t0;
        a = cfg_valid_i && cfg_ready_o;
        r = rst_i;
        po = pad_oen_o; pp = pad_puen_o; ps = pad_slw_o; pm = pad_smt_o; pd = pad_drv_o;
        @(posedge clk);
        #1;
        cyc++;
        if (a) begin
            acc_q.push_back(cyc);
            n_acc++;
            last_acc = cyc;
        end
        chk("done_err_excl", 32'(cfg_done_o & cfg_err_o), 0);
        if (!r) begin
            for (int k = 0; k < NP; k++) dmask[2*k +: 2] = {2{~po[k]}};
            chk("drv_frozen", 32'((pad_drv_o ^ pd) & dmask), 0);
            chk("pull_slw_smt_frozen", 32'({pad_puen_o ^ pp, pad_slw_o ^ ps, pad_smt_o ^ pm} & {3{~po}}), 0);
        end
        if (cfg_done_o || cfg_err_o) begin
            if (cfg_done_o) done_cyc = cyc;
            chk("resp_expected", 32'(q.size() > 0 && acc_q.size() > 0), 1);
            if (q.size() > 0 && acc_q.size() > 0) begin
                e = q.pop_front();
                t0 = acc_q.pop_front();
                chk("resp_is_err", 32'(cfg_err_o), 32'(e.err));
                chk("resp_latency", 32'(cyc - t0), 32'(e.lat));
                chk("resp_oen", 32'(pad_oen_o), 32'(e.oen));
                chk("resp_puen", 32'(pad_puen_o), 32'(e.puen));
                chk("resp_drv", 32'(pad_drv_o), 32'(e.drv));
                chk("resp_slw", 32'(pad_slw_o), 32'(e.slw));
                chk("resp_smt", 32'(pad_smt_o), 32'(e.smt));
            end
        end
    endtask
    task automatic wait_idle(input int n);
        for (int i = 0; i < n && q.size() != 0; i++) tick();
        chk("idle_timeout", 32'(q.size()), 0);
    endtask
    initial begin
        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_idx_i = '0; cfg_data_i = '0;
        model_reset();
        // reset defaults
        tick();
        tick();
        chk("rst_ready", 32'(cfg_ready_o), 0);
        chk("rst_done", 32'(cfg_done_o), 0);
        chk("rst_err", 32'(cfg_err_o), 0);
        rst_i = 1'b0;
        repeat (3) tick();
        check_all("rst");
        chk("idle_ready", 32'(cfg_ready_o), 1);
        chk("idle_done_err", 32'({cfg_done_o, cfg_err_o}), 0);
        // pad 2 already tristated: fields at E0, OEN/done at E_S
        issue(2, 6'b011110);
        tick();
        cfg_valid_i = 1'b0;
        chk("t2_e0_oen", 32'(pad_oen_o[2]), 1);
        chk("t2_e0_puen", 32'(pad_puen_o[2]), 1);
        chk("t2_e0_drv", 32'(pad_drv_o[5:4]), 3);
        chk("t2_e0_slw_smt", 32'({pad_slw_o[2], pad_smt_o[2]}), 2);
        chk("t2_e0_ready", 32'(cfg_ready_o), 0);
        repeat (S - 1) tick();
        chk("t2_e3_oen", 32'(pad_oen_o[2]), 1);
        chk("t2_e3_done", 32'(cfg_done_o), 0);
        tick();
        chk("t2_e4_oen", 32'(pad_oen_o[2]), 0);
        chk("t2_e4_done", 32'(cfg_done_o), 1);
        chk("t2_e4_ready", 32'(cfg_ready_o), 1);
        check_all("t2");
        // pad 2 driving: tristate at E0, fields at E_S, OEN/done at E_2S
        issue(2, 6'b000101);
        tick();
        cfg_valid_i = 1'b0;
        chk("t3_e0_oen", 32'(pad_oen_o[2]), 1);
        chk("t3_e0_drv_old", 32'(pad_drv_o[5:4]), 3);
        chk("t3_e0_puen_old", 32'(pad_puen_o[2]), 1);
        repeat (S) tick();
        chk("t3_e4_drv", 32'(pad_drv_o[5:4]), 1);
        chk("t3_e4_puen", 32'(pad_puen_o[2]), 0);
        chk("t3_e4_slw_smt", 32'({pad_slw_o[2], pad_smt_o[2]}), 1);
        chk("t3_e4_oen", 32'(pad_oen_o[2]), 1);
        chk("t3_e4_done", 32'(cfg_done_o), 0);
        repeat (S) tick();
        chk("t3_e8_oen", 32'(pad_oen_o[2]), 0);
        chk("t3_e8_done", 32'(cfg_done_o), 1);
        check_all("t3");
        // out-of-range index, then a valid request immediately after
        issue(7, 6'b111111);
        tick();
        chk("t4_err", 32'(cfg_err_o), 1);
        chk("t4_err_ready", 32'(cfg_ready_o), 1);
        chk("t4_err_done", 32'(cfg_done_o), 0);
        check_all("t4_err");
        issue(1, 6'b100110);
        tick();
        cfg_valid_i = 1'b0;
        chk("t4_err_pulse_end", 32'(cfg_err_o), 0);
        chk("t4_p1_fields", 32'({pad_puen_o[1], pad_drv_o[3:2], pad_slw_o[1], pad_smt_o[1]}), 32'b00110);
        wait_idle(3 * S);
        check_all("t4");
        // reset in the middle of a driving-pad sequence
        issue(2, 6'b011111);
        tick();
        cfg_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        q.delete();
        acc_q.delete();
        model_reset();
        check_all("t5_rst");
        chk("t5_rst_done", 32'(cfg_done_o), 0);
        chk("t5_rst_ready", 32'(cfg_ready_o), 0);
        rst_i = 1'b0;
        #1;
        chk("t5_ready_after", 32'(cfg_ready_o), 1);
        repeat (2 * S + 2) tick();
        check_all("t5_after");
        chk("t5_no_done", 32'(cfg_done_o), 0);
        // valid held high across two queued requests
        base = n_acc;
        issue(0, 6'b001001);
        tick();
        issue(3, 6'b001011);
        for (int i = 0; i < 4 * S && n_acc - base < 2; i++) tick();
        cfg_valid_i = 1'b0;
        chk("t6_two_accepts", 32'(n_acc - base), 2);
        chk("t6_accept_on_done", 32'(last_acc - done_cyc), 1);
        wait_idle(3 * S);
        repeat (3) tick();
        chk("t6_no_extra_accept", 32'(n_acc - base), 2);
        check_all("t6");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
